vector_op_sequencer: RTL and testbench
======================================

// Module: vector_op_sequencer
// PURPOSE
//  CFU-side controller that accepts CPU commands, holds vl state, and steps each
//  vector opcode across elements 0..vl-1. Each step drives the downstream
//  decoder_block/datapath with a held copy of the command plus an element index.
//  Returns one response per command: granted vl, an element count, or a reduction result.
// PARAMETERS
//  VLEN_MAX  16  maximum elements per vector op; vsetvli clamps to this value
//  WB_LAT    1   cycles from last element step until acc_result is valid (>=1)
// PORTS
//  clk                      in   1           single clock, all state on posedge
//  reset                    in   1           synchronous, active-high
//  cmd_valid                in   1           CPU command valid
//  cmd_ready                out  1           command accepted when valid&ready
//  cmd_payload_function_id  in   10          [9:5] opcode, [4:0] dest vreg
//  cmd_payload_inputs_0     in   32          rs1 operand
//  cmd_payload_inputs_1     in   32          rs2 operand
//  rsp_valid                out  1           response valid
//  rsp_ready                in   1           CPU accepts response
//  rsp_payload_outputs_0    out  32          response data
//  seq_valid                out  1           per-element step strobe to decoder cmd_valid
//  seq_function_id          out  10          latched function_id, held through op
//  seq_inputs_0             out  32          latched inputs_0
//  seq_inputs_1             out  32          latched inputs_1
//  elem_idx                 out  IDX_W       current element, IDX_W=$clog2(VLEN_MAX)
//  vl                       out  VL_W        current vl, VL_W=$clog2(VLEN_MAX+1)
//  acc_result               in   32          datapath reduction result
// BEHAVIOUR
//  Reset: state=IDLE; vl=0; elem_idx=0; seq_* =0; rsp_valid=0; rsp data=0.
//  Reset mid-op aborts: no rsp; vl=0.
//  IDLE: cmd_ready=1; elsewhere 0. On accept, latch fid/inputs into seq_*.
//   - opcode 5'h17 vsetvli: vl<=min(inputs_0 (unsigned 32b), VLEN_MAX); ->RESP,
//     data=new vl. No seq_valid.
//   - 5'h07,5'h15,5'h0D,5'h04,5'h1D: if vl==0 ->RESP data=0; else elem_idx<=0 ->EXEC.
//   - any other opcode: ->RESP data=0; vl unchanged; no steps.
//  EXEC: seq_valid=1 every cycle; elem_idx increments by 1 per cycle.
//   - Exactly vl consecutive steps, idx 0..vl-1, no bubbles.
//   - After the step with elem_idx==vl-1: ->DRAIN, seq_valid=0.
//  DRAIN: wait WB_LAT cycles via counter; on the final cycle ->RESP.
//   - Rsp data = acc_result sampled that cycle for opcodes 5'h0D/5'h1D, else vl.
//  RESP: rsp_valid=1; data stable until rsp_ready. On rsp_valid&rsp_ready ->IDLE.
//   - cmd_ready rises the following cycle; no cmd/rsp overlap.
//  Latency: vsetvli accept->rsp_valid = 1 cycle; vector op = 1+vl+WB_LAT cycles.
//  vl is changed only by vsetvli and reset; seq_* are stable from accept until return to IDLE.
//  elem_idx never exceeds VLEN_MAX-1; all counters are unsigned with no wrap.
// STRUCTURE
//  Shared package vec_cfu_pkg:
//   - OP_VSETVLI=5'h17, OP_VLOAD=5'h07, OP_VADDI=5'h15, OP_VACC=5'h0D,
//     OP_VMUL=5'h04, OP_VBACC=5'h1D
//   - state encoding IDLE/EXEC/DRAIN/RESP; shared with decoder_block
//  Single flat FSM; no sub-module required. decoder_block instantiates alongside
//  in the core, fed from seq_valid/seq_function_id/seq_inputs_*.
// TESTING
//  1 vsetvli inputs_0=5 -> rsp_valid next cycle, data=5, vl=5, seq_valid never high.
//  2 vsetvli inputs_0=40 (VLEN_MAX=16) -> data=16; then inputs_0=0 -> data=0, vl=0.
//  3 vl=4, vmul fid={5'h04,5'd3}, in0=1, in1=2
//    -> seq_valid 4 cycles, elem_idx 0,1,2,3, seq_* held;
//    -> rsp data=4 after WB_LAT.
//  4 vl=3, vbacc with acc_result=32'h1234 at DRAIN end -> rsp data=32'h1234.
//  5 vl=0 vaddi -> rsp data=0, no steps; opcode 5'h1F -> rsp data=0, vl unchanged.
//  6 rsp_ready low 5 cycles -> rsp_valid and data stable, cmd_ready=0;
//    reset at elem_idx=2 -> next cycle seq_valid=0, cmd_ready=1, vl=0, no rsp.

Source files
------------

// File: rtl/vec_cfu_pkg.sv
// Opcode constants, sequencer state encoding and opcode classification helpers
// shared by the vector sequencer and the decoder that sits alongside it.
package vec_cfu_pkg;

  localparam logic [4:0] OP_VSETVLI = 5'h17;
  localparam logic [4:0] OP_VLOAD   = 5'h07;
  localparam logic [4:0] OP_VADDI   = 5'h15;
  localparam logic [4:0] OP_VACC    = 5'h0D;
  localparam logic [4:0] OP_VMUL    = 5'h04;
  localparam logic [4:0] OP_VBACC   = 5'h1D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Opcodes that are stepped element by element across 0..vl-1.
  function automatic logic is_vec_op(input logic [4:0] op);
    return (op == OP_VLOAD) || (op == OP_VADDI) || (op == OP_VACC) ||
           (op == OP_VMUL)  || (op == OP_VBACC);
  endfunction

  // Reductions answer with the datapath accumulator instead of the element count.
  function automatic logic is_reduction(input logic [4:0] op);
    return (op == OP_VACC) || (op == OP_VBACC);
  endfunction

endpackage

// File: rtl/vector_op_sequencer_if.sv
// CPU-facing command/response channel of the vector CFU.
interface vector_op_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

endinterface

// File: rtl/vector_op_sequencer.sv
// Accepts one CPU command at a time, holds vl, steps vector opcodes across
// elements 0..vl-1 for the downstream decoder, then returns a single response.
module vector_op_sequencer
  import vec_cfu_pkg::*;
#(
  parameter int VLEN_MAX = 16,
  parameter int WB_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  vector_op_sequencer_if.slave          cpu,
  output logic                          seq_valid,
  output logic [9:0]                    seq_function_id,
  output logic [31:0]                   seq_inputs_0,
  output logic [31:0]                   seq_inputs_1,
  output logic [$clog2(VLEN_MAX)-1:0]   elem_idx,
  output logic [$clog2(VLEN_MAX+1)-1:0] vl,
  input  logic [31:0]                   acc_result
);

  localparam int IDX_W = $clog2(VLEN_MAX);
  localparam int VL_W  = $clog2(VLEN_MAX + 1);
  localparam int CNT_W = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;

  seq_state_e         state_q;
  logic [VL_W-1:0]    vl_q;
  logic [IDX_W-1:0]   elem_idx_q;
  logic [CNT_W-1:0]   drain_cnt_q;
  logic [9:0]         seq_fid_q;
  logic [31:0]        seq_in0_q;
  logic [31:0]        seq_in1_q;
  logic               seq_valid_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;

  logic [VL_W-1:0]    vl_set_d;
  logic [4:0]         cmd_op;
  logic               last_step;

  assign cmd_op = cpu.cmd_payload_function_id[9:5];

  // vsetvli grants the full requested length, saturating at VLEN_MAX.
  always_comb begin
    vl_set_d = cpu.cmd_payload_inputs_0[VL_W-1:0];
    if (cpu.cmd_payload_inputs_0 > 32'(VLEN_MAX)) begin
      vl_set_d = VL_W'(VLEN_MAX);
    end
  end

  assign last_step = (VL_W'(elem_idx_q) == (vl_q - VL_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vl_q        <= '0;
      elem_idx_q  <= '0;
      drain_cnt_q <= '0;
      seq_fid_q   <= '0;
      seq_in0_q   <= '0;
      seq_in1_q   <= '0;
      seq_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu.cmd_valid && cmd_ready_q) begin
            seq_fid_q   <= cpu.cmd_payload_function_id;
            seq_in0_q   <= cpu.cmd_payload_inputs_0;
            seq_in1_q   <= cpu.cmd_payload_inputs_1;
            cmd_ready_q <= 1'b0;
            if (cmd_op == OP_VSETVLI) begin
              vl_q        <= vl_set_d;
              rsp_data_q  <= 32'(vl_set_d);
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else if (is_vec_op(cmd_op) && (vl_q != '0)) begin
              elem_idx_q  <= '0;
              seq_valid_q <= 1'b1;
              state_q     <= ST_EXEC;
            end else begin
              // Unknown opcodes and empty vectors complete immediately with zero.
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end

        ST_EXEC: begin
          if (last_step) begin
            seq_valid_q <= 1'b0;
            drain_cnt_q <= CNT_W'(WB_LAT - 1);
            state_q     <= ST_DRAIN;
          end else begin
            elem_idx_q <= elem_idx_q + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            rsp_data_q  <= is_reduction(seq_fid_q[9:5]) ? acc_result : 32'(vl_q);
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (cpu.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          seq_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu.cmd_ready             = cmd_ready_q;
  assign cpu.rsp_valid             = rsp_valid_q;
  assign cpu.rsp_payload_outputs_0 = rsp_data_q;
  assign seq_valid                 = seq_valid_q;
  assign seq_function_id           = seq_fid_q;
  assign seq_inputs_0              = seq_in0_q;
  assign seq_inputs_1              = seq_in1_q;
  assign elem_idx                  = elem_idx_q;
  assign vl                        = vl_q;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Scoreboard bench: a behavioural model queues expected steps and responses per
// command; independent monitors compare whatever the sequencer presents.
module tb_vector_op_sequencer;

  localparam int VLEN_MAX = 16;
  localparam int WB_LAT   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        seq_valid;
  logic [9:0]  seq_function_id;
  logic [31:0] seq_inputs_0;
  logic [31:0] seq_inputs_1;
  logic [3:0]  elem_idx;
  logic [4:0]  vl;
  logic [31:0] acc_result;

  always #5 clk = ~clk;

  vector_op_sequencer_if cpu ();

  vector_op_sequencer #(.VLEN_MAX(VLEN_MAX), .WB_LAT(WB_LAT)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .cpu             (cpu.slave),
    .seq_valid       (seq_valid),
    .seq_function_id (seq_function_id),
    .seq_inputs_0    (seq_inputs_0),
    .seq_inputs_1    (seq_inputs_1),
    .elem_idx        (elem_idx),
    .vl              (vl),
    .acc_result      (acc_result)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          vl;
  } rsp_t;

  typedef struct {
    int          idx;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
  } step_t;

  rsp_t        rsp_q[$];
  step_t       step_q[$];
  rsp_t        r_mon;
  step_t       s_mon;
  int          tests_run = 0;
  int          failed = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          model_vl = 0;
  int          stall_left = 0;
  bit          in_rsp = 1'b0;
  logic [31:0] held_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response consumer: mostly-ready, with an optional forced stall.
  initial begin
    cpu.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        cpu.rsp_ready = 1'b0;
        if (cpu.rsp_valid) stall_left--;
      end else begin
        cpu.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Step monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && seq_valid) begin
        if (step_q.size() == 0) begin
          chk("unexpected_step", 32'd1, 32'd0);
        end else begin
          s_mon = step_q.pop_front();
          chk("elem_idx", 32'(elem_idx), 32'(s_mon.idx));
          chk("seq_function_id", 32'(seq_function_id), 32'(s_mon.fid));
          chk("seq_inputs_0", seq_inputs_0, s_mon.in0);
          chk("seq_inputs_1", seq_inputs_1, s_mon.in1);
        end
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_rsp = 1'b0;
      end else if (cpu.rsp_valid) begin
        chk("cmd_ready_during_rsp", 32'(cpu.cmd_ready), 32'd0);
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            r_mon = rsp_q.pop_front();
            chk("rsp_data", cpu.rsp_payload_outputs_0, r_mon.data);
            chk("rsp_latency", 32'(cyc - acc_cyc), 32'(r_mon.lat));
            chk("vl", 32'(vl), 32'(r_mon.vl));
            chk("steps_done", 32'(step_q.size()), 32'd0);
          end
          held_data = cpu.rsp_payload_outputs_0;
        end else begin
          chk("rsp_stable", cpu.rsp_payload_outputs_0, held_data);
        end
        if (cpu.rsp_ready) in_rsp = 1'b0;
      end
    end
  end

  function automatic bit model_is_vec(input logic [4:0] op);
    return op inside {5'h07, 5'h15, 5'h0D, 5'h04, 5'h1D};
  endfunction

  // Issue one command; entered and left on a negative edge.
  task automatic issue(input logic [9:0] fid, input logic [31:0] in0,
                       input logic [31:0] in1, input logic [31:0] acc);
    logic [4:0]  op;
    logic [31:0] d;
    int          lat;
    int          guard;
    rsp_t        r;
    step_t       s;
    op = fid[9:5];
    cpu.cmd_valid               = 1'b1;
    cpu.cmd_payload_function_id = fid;
    cpu.cmd_payload_inputs_0    = in0;
    cpu.cmd_payload_inputs_1    = in1;
    guard = 0;
    while (!cpu.cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("cmd_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    acc_result = acc;
    if (op == 5'h17) begin
      model_vl = (in0 > 32'(VLEN_MAX)) ? VLEN_MAX : int'(in0);
      d   = 32'(model_vl);
      lat = 1;
    end else if (model_is_vec(op) && model_vl > 0) begin
      for (int i = 0; i < model_vl; i++) begin
        s.idx = i; s.fid = fid; s.in0 = in0; s.in1 = in1;
        step_q.push_back(s);
      end
      d   = (op == 5'h0D || op == 5'h1D) ? acc : 32'(model_vl);
      lat = 1 + model_vl + WB_LAT;
    end else begin
      d   = 32'd0;
      lat = 1;
    end
    r.data = d; r.lat = lat; r.vl = model_vl;
    rsp_q.push_back(r);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cpu.cmd_valid = 1'b0;
    cpu.cmd_payload_inputs_0 = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (rsp_q.size() != 0 || in_rsp || !cpu.cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        chk("drain_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  logic [4:0] op_tbl [7];
  logic [4:0] op;
  int         guard;

  initial begin
    op_tbl = '{5'h17, 5'h07, 5'h15, 5'h0D, 5'h04, 5'h1D, 5'h1F};
    reset = 1'b1;
    acc_result = 32'd0;
    cpu.cmd_valid = 1'b0;
    cpu.cmd_payload_function_id = '0;
    cpu.cmd_payload_inputs_0 = '0;
    cpu.cmd_payload_inputs_1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cpu.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(cpu.rsp_valid), 32'd0);
    chk("reset_rsp_data", cpu.rsp_payload_outputs_0, 32'd0);
    chk("reset_seq_valid", 32'(seq_valid), 32'd0);
    chk("reset_vl", 32'(vl), 32'd0);
    chk("reset_elem_idx", 32'(elem_idx), 32'd0);
    chk("reset_seq_fid", 32'(seq_function_id), 32'd0);
    chk("reset_seq_in0", seq_inputs_0, 32'd0);

    // Directed scenarios
    issue({5'h17, 5'd1}, 32'd5, 32'd0, 32'd0);
    issue({5'h17, 5'd1}, 32'd40, 32'd0, 32'd0);
    issue({5'h17, 5'd1}, 32'd0, 32'd0, 32'd0);
    issue({5'h17, 5'd1}, 32'd4, 32'd0, 32'd0);
    issue({5'h04, 5'd3}, 32'd1, 32'd2, 32'hdead_beef);
    issue({5'h17, 5'd1}, 32'd3, 32'd0, 32'd0);
    issue({5'h1D, 5'd2}, 32'd7, 32'd8, 32'h0000_1234);
    issue({5'h17, 5'd1}, 32'd0, 32'd0, 32'd0);
    issue({5'h15, 5'd4}, 32'd9, 32'd9, 32'd0);
    issue({5'h17, 5'd1}, 32'd16, 32'd0, 32'd0);
    issue({5'h1F, 5'd0}, 32'd3, 32'd3, 32'd0);
    issue({5'h0D, 5'd6}, 32'd1, 32'd1, 32'hcafe_0001);
    wait_idle();
    stall_left = 5;
    issue({5'h17, 5'd1}, 32'd7, 32'd0, 32'd0);
    wait_idle();

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : op_tbl[$urandom_range(0, 6)];
      if (op == 5'h17) begin
        issue({op, 5'($urandom)},
              ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 20)),
              $urandom, $urandom);
      end else begin
        issue({op, 5'($urandom)}, $urandom, $urandom, $urandom);
      end
    end
    wait_idle();

    // Reset in the middle of a vector op
    issue({5'h17, 5'd1}, 32'd4, 32'd0, 32'd0);
    issue({5'h04, 5'd3}, 32'd1, 32'd2, 32'd0);
    guard = 0;
    while (!(seq_valid && elem_idx == 4'd2)) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        chk("reach_idx2_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
    rsp_q.delete();
    step_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_vl = 0;
    @(negedge clk);
    chk("abort_seq_valid", 32'(seq_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cpu.cmd_ready), 32'd1);
    chk("abort_vl", 32'(vl), 32'd0);
    chk("abort_rsp_valid", 32'(cpu.rsp_valid), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", 32'(cpu.rsp_valid), 32'd0);
    issue({5'h0D, 5'd1}, 32'd1, 32'd1, 32'h5555_aaaa);
    issue({5'h17, 5'd1}, 32'd9, 32'd0, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
